// File: rtl/vid_pkg.sv
// Shared types and default geometry for the video box-overlay stage.
package vid_pkg;

  localparam int DEF_DATAW = 24;
  localparam int DEF_SCRW  = 1920;
  localparam int DEF_SCRH  = 1080;
  localparam int DEF_CNTW  = 13;

  typedef logic [DEF_CNTW-1:0] coord_t;

  typedef enum logic {
    WAIT_SOF,
    ACTIVE
  } vid_state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer whose head entry is the registered output beat.
module axis_skid_buf #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] data0;
  logic [W-1:0] data1;
  logic [1:0]   count;
  logic         ready_q;
  logic         in_fire;
  logic         out_fire;

  // Ready depends only on registered occupancy, so there is no path from m_ready.
  assign s_ready  = ready_q & (count != 2'd2);
  assign m_valid  = (count != 2'd0);
  assign m_data   = data0;
  assign in_fire  = s_valid & s_ready;
  assign out_fire = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count   <= 2'd0;
      data0   <= '0;
      data1   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      count   <= count + {1'b0, in_fire} - {1'b0, out_fire};
      if (in_fire && (count == 2'd0 || (count == 2'd1 && out_fire))) begin
        data0 <= s_data;
      end else if (out_fire && count == 2'd2) begin
        data0 <= data1;
      end
      if (in_fire && count == 2'd1 && !out_fire) begin
        data1 <= s_data;
      end
    end
  end

endmodule

// File: rtl/axis_vid_box_overlay.sv
// Tracks pixel position in an AXI-Stream video frame, checks line/frame framing
// and paints a one-pixel box outline before handing beats to the output skid.
module axis_vid_box_overlay
  import vid_pkg::*;
#(
  parameter int DATAW = DEF_DATAW,
  parameter int SCRW  = DEF_SCRW,
  parameter int SCRH  = DEF_SCRH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [CNTW-1:0]  box_x,
  input  logic [CNTW-1:0]  box_y,
  input  logic [CNTW-1:0]  box_w,
  input  logic [CNTW-1:0]  box_h,
  input  logic [DATAW-1:0] box_color,
  input  logic [DATAW-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [DATAW-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             err_eol_early,
  output logic             err_eol_late,
  output logic             err_sof_early,
  output logic [15:0]      frame_cnt
);

  localparam logic [CNTW-1:0] LAST_X = CNTW'(SCRW - 1);
  localparam logic [CNTW-1:0] LAST_Y = CNTW'(SCRH - 1);

  vid_state_t       state, state_n;
  logic [CNTW-1:0]  x_q, y_q, x_n, y_n, cx, cy;
  logic [CNTW-1:0]  shd_x, shd_y, shd_w, shd_h;
  logic [CNTW-1:0]  eff_x, eff_y, eff_w, eff_h;
  logic [DATAW-1:0] shd_color, eff_color, pix;
  logic [CNTW:0]    px, py, bx, by, x2, y2;
  logic             in_ready, accept, sof, take, forward;
  logic             eol_early, eol_late, sof_early;
  logic             on_h, on_v, box_on;
  logic [DATAW+1:0] out_data;

  assign s_axis_tready = in_ready;
  assign accept  = s_axis_tvalid & in_ready;
  assign sof     = accept & s_axis_tuser;
  assign take    = (state == ACTIVE) | s_axis_tuser;
  assign forward = accept & take;

  // A SOF beat belongs to the new frame, so it already uses the fresh box settings.
  assign eff_x     = sof ? box_x     : shd_x;
  assign eff_y     = sof ? box_y     : shd_y;
  assign eff_w     = sof ? box_w     : shd_w;
  assign eff_h     = sof ? box_h     : shd_h;
  assign eff_color = sof ? box_color : shd_color;

  assign cx = s_axis_tuser ? '0 : x_q;
  assign cy = s_axis_tuser ? '0 : y_q;

  assign px = {1'b0, cx};
  assign py = {1'b0, cy};
  assign bx = {1'b0, eff_x};
  assign by = {1'b0, eff_y};
  assign x2 = bx + {1'b0, eff_w} - (CNTW+1)'(1);
  assign y2 = by + {1'b0, eff_h} - (CNTW+1)'(1);

  assign on_h   = ((py == by) || (py == y2)) && (px >= bx) && (px <= x2);
  assign on_v   = ((px == bx) || (px == x2)) && (py >= by) && (py <= y2);
  assign box_on = (eff_w != '0) && (eff_h != '0) && (on_h || on_v);
  assign pix    = (en && box_on) ? eff_color : s_axis_tdata;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= WAIT_SOF;
      x_q           <= '0;
      y_q           <= '0;
      shd_x         <= '0;
      shd_y         <= '0;
      shd_w         <= '0;
      shd_h         <= '0;
      shd_color     <= '0;
      err_eol_early <= 1'b0;
      err_eol_late  <= 1'b0;
      err_sof_early <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state         <= state_n;
      x_q           <= x_n;
      y_q           <= y_n;
      err_eol_early <= eol_early;
      err_eol_late  <= eol_late;
      err_sof_early <= sof_early;
      if (sof) begin
        shd_x     <= box_x;
        shd_y     <= box_y;
        shd_w     <= box_w;
        shd_h     <= box_h;
        shd_color <= box_color;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // SOF restarts the position first; line-end handling then runs on the restarted x.
  always_comb begin
    state_n   = state;
    x_n       = x_q;
    y_n       = y_q;
    eol_early = 1'b0;
    eol_late  = 1'b0;
    sof_early = 1'b0;
    if (forward) begin
      state_n = ACTIVE;
      if (state == ACTIVE && s_axis_tuser) sof_early = 1'b1;
      if (s_axis_tlast || cx == LAST_X) begin
        eol_early = s_axis_tlast && (cx != LAST_X);
        eol_late  = !s_axis_tlast;
        x_n       = '0;
        y_n       = cy + CNTW'(1);
        if (cy == LAST_Y) state_n = WAIT_SOF;
      end else begin
        x_n = cx + CNTW'(1);
        y_n = cy;
      end
    end
  end

  axis_skid_buf #(
    .W(DATAW + 2)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .s_data  ({s_axis_tuser, s_axis_tlast, pix}),
    .s_valid (s_axis_tvalid & take),
    .s_ready (in_ready),
    .m_data  (out_data),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = out_data;

endmodule

// File: tb/tb_axis_vid_box_overlay.sv
// Self-checking bench for axis_vid_box_overlay on a 16x8 screen with a
// position-tracking reference model and a scoreboard of expected output beats.
module tb_axis_vid_box_overlay;

  localparam int DATAW = 24;
  localparam int SCRW  = 16;
  localparam int SCRH  = 8;
  localparam int CNTW  = 13;

  logic             clk = 1'b0;
  logic             rstn;
  logic             en;
  logic [CNTW-1:0]  box_x, box_y, box_w, box_h;
  logic [DATAW-1:0] box_color;
  logic [DATAW-1:0] s_tdata;
  logic             s_tvalid, s_tuser, s_tlast, s_tready;
  logic [DATAW-1:0] m_tdata;
  logic             m_tvalid, m_tuser, m_tlast, m_tready;
  logic             err_ee, err_el, err_se;
  logic [15:0]      frame_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DATAW+1:0] exp_q[$];
  bit               in_frame;
  int               mx, my, sbx, sby, sbw, sbh;
  logic [DATAW-1:0] scol;
  int               exp_frames, exp_ee, exp_el, exp_se;

  // monitor state
  int               ready_mode = 0;
  int               n_ee = 0, n_el = 0, n_se = 0, red_cnt = 0;
  bit               stalled = 0;
  logic [DATAW+1:0] held;
  bit               cap_armed = 0;
  logic             first_user;
  bit               gaps = 0;
  bit               rand_en = 0;

  always #5 clk = ~clk;

  axis_vid_box_overlay #(
    .DATAW(DATAW), .SCRW(SCRW), .SCRH(SCRH), .CNTW(CNTW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en),
    .box_x         (box_x),
    .box_y         (box_y),
    .box_w         (box_w),
    .box_h         (box_h),
    .box_color     (box_color),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .err_eol_early (err_ee),
    .err_eol_late  (err_el),
    .err_sof_early (err_se),
    .frame_cnt     (frame_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s: observed event missing expected event within bound", tag);
  endtask

  // Behavioural model: walks the frame with integer coordinates.
  task automatic model_accept(input logic [DATAW-1:0] d, input logic u, input logic l);
    int x2, y2;
    bit on;
    logic [DATAW-1:0] o;
    if (!in_frame && !u) return;
    if (u) begin
      exp_frames++;
      if (in_frame) exp_se++;
      in_frame = 1;
      mx = 0; my = 0;
      sbx = int'(box_x); sby = int'(box_y); sbw = int'(box_w); sbh = int'(box_h);
      scol = box_color;
    end
    x2 = sbx + sbw - 1;
    y2 = sby + sbh - 1;
    on = (sbw > 0) && (sbh > 0) &&
         ((((my == sby) || (my == y2)) && mx >= sbx && mx <= x2) ||
          (((mx == sbx) || (mx == x2)) && my >= sby && my <= y2));
    o = (en && on) ? scol : d;
    exp_q.push_back({u, l, o});
    if (l || mx == SCRW - 1) begin
      if (l && mx != SCRW - 1) exp_ee++;
      if (!l) exp_el++;
      mx = 0;
      my++;
      if (my == SCRH) in_frame = 0;
    end else begin
      mx++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    in_frame   = 0;
    exp_frames = 0;
  endtask

  function automatic logic [DATAW-1:0] rand_pix();
    return DATAW'($urandom) & 24'h00FFFF;
  endfunction

  // Entered and left at posedge+1; the model sees the beat at the edge it is accepted.
  task automatic send_beat(input logic [DATAW-1:0] d, input logic u, input logic l);
    int n;
    if (gaps && $urandom_range(0, 2) == 0) begin
      s_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    if (rand_en) en = 1'($urandom_range(0, 1));
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        model_accept(d, u, l);
        #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        fail_now("accept_timeout");
        break;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_line(input int n, input bit sof);
    for (int i = 0; i < n; i++) send_beat(rand_pix(), sof && (i == 0), i == n - 1);
  endtask

  task automatic send_frame();
    for (int y = 0; y < SCRH; y++) send_line(SCRW, y == 0);
  endtask

  task automatic set_box(input int x, input int y, input int w, input int h, input logic [DATAW-1:0] c);
    box_x = CNTW'(x); box_y = CNTW'(y); box_w = CNTW'(w); box_h = CNTW'(h); box_color = c;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_counters();
    check("frame_cnt", frame_cnt, exp_frames[15:0]);
    check("eol_early_cnt", n_ee, exp_ee);
    check("eol_late_cnt", n_el, exp_el);
    check("sof_early_cnt", n_se, exp_se);
  endtask

  // Output monitor: drives m_tready, checks stalls and scoreboards delivered beats.
  always @(negedge clk) begin
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
    if (!rstn) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        check("stall_valid", m_tvalid, 1'b1);
        check("stall_beat", {m_tuser, m_tlast, m_tdata}, held);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else check("out_beat", {m_tuser, m_tlast, m_tdata}, exp_q.pop_front());
        if (m_tdata == 24'hFF0000) red_cnt++;
        if (cap_armed) begin
          first_user = m_tuser;
          cap_armed  = 0;
        end
      end
      stalled = m_tvalid && !m_tready;
      held    = {m_tuser, m_tlast, m_tdata};
    end
    if (err_ee === 1'b1) n_ee++;
    if (err_el === 1'b1) n_el++;
    if (err_se === 1'b1) n_se++;
  end

  initial begin
    int ee0, se0;
    rstn = 1'b0; en = 1'b0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    set_box(0, 0, 0, 0, '0);
    model_reset();
    exp_ee = 0; exp_el = 0; exp_se = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tdata", {m_tuser, m_tlast, m_tdata}, '0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_errs", {err_ee, err_el, err_se}, 3'b000);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", s_tready, 1'b1);

    // 1: fixed box, two frames
    $display("[TB] test 1: box (2,1,4,3) red, two frames");
    en = 1'b1;
    set_box(2, 1, 4, 3, 24'hFF0000);
    send_frame();
    send_frame();
    drain("drain_t1");
    check("t1_red_pixels", red_cnt, 20);
    check("t1_frame_cnt", frame_cnt, 16'd2);
    check("t1_no_errs", n_ee + n_el + n_se, 0);
    check_counters();

    // 2: no box / disabled, plus a box hanging off the screen edge
    $display("[TB] test 2: pass-through and clipped box");
    set_box(2, 1, 0, 3, 24'hFF0000);
    send_frame();
    set_box(2, 1, 4, 3, 24'hFF0000);
    en = 1'b0;
    send_frame();
    drain("drain_t2");
    check("t2_red_pixels", red_cnt, 20);
    en = 1'b1;
    set_box(13, 5, 10, 10, 24'h123456);
    send_frame();
    set_box(8191, 8191, 8191, 8191, 24'h654321);
    send_frame();
    drain("drain_t2b");
    check_counters();

    // 3: random backpressure, gaps, en and box
    $display("[TB] test 3: random m_tready and boxes");
    ready_mode = 1; gaps = 1; rand_en = 1;
    for (int f = 0; f < 3; f++) begin
      set_box($urandom_range(0, SCRW), $urandom_range(0, SCRH), $urandom_range(0, SCRW),
              $urandom_range(0, SCRH), DATAW'($urandom));
      send_frame();
    end
    drain("drain_t3");
    check_counters();
    ready_mode = 0; gaps = 0; rand_en = 0; en = 1'b1;

    // 4: stream joins mid-frame
    $display("[TB] test 4: mid-frame start");
    cap_armed = 1;
    send_line(SCRW - 5, 0);
    for (int y = 4; y < SCRH; y++) send_line(SCRW, 0);
    set_box(1, 1, 3, 3, 24'hFF0000);
    send_frame();
    drain("drain_t4");
    check("t4_first_tuser", first_user, 1'b1);
    check_counters();

    // 5: framing errors
    $display("[TB] test 5: framing errors");
    ee0 = n_ee; se0 = n_se;
    set_box(0, 3, 4, 2, 24'h00FF00);
    send_line(SCRW, 1);
    send_line(SCRW, 0);
    send_line(10, 0);
    send_line(SCRW, 0);
    drain("drain_t5a");
    check("t5_one_early_eol", n_ee - ee0, 1);
    set_box(1, 1, 3, 3, 24'h0000FF);
    send_line(SCRW, 1);
    for (int y = 1; y < SCRH; y++) send_line(SCRW, 0);
    drain("drain_t5b");
    check("t5_one_early_sof", n_se - se0, 1);
    send_line(SCRW, 1);
    send_line(SCRW + 1, 0);
    for (int y = 2; y < SCRH; y++) send_line(SCRW, 0);
    send_line(SCRW, 1);
    send_line(1, 1);
    for (int y = 1; y < SCRH; y++) send_line(SCRW, 0);
    drain("drain_t5c");
    check_counters();

    // 6: reset mid-line with the output stalled
    $display("[TB] test 6: reset while stalled");
    ready_mode = 2;
    send_beat(rand_pix(), 1'b1, 1'b0);
    send_beat(rand_pix(), 1'b0, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("t6_m_tvalid", m_tvalid, 1'b0);
    check("t6_s_tready", s_tready, 1'b0);
    rstn = 1'b1;
    model_reset();
    ready_mode = 0;
    cap_armed = 1;
    send_line(SCRW - 2, 0);
    send_line(SCRW, 0);
    send_frame();
    drain("drain_t6");
    check("t6_first_tuser", first_user, 1'b1);
    check("t6_frame_cnt", frame_cnt, 16'd1);
    check_counters();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
